// File: rtl/wb_trace_buffer_if.sv
// Pipeline-facing and display-facing signals of the commit-trace buffer.
// dbg_load is a one-cycle strobe: high in the cycle right after the display register loads, when dbg_disp holds the new entry.
interface wb_trace_buffer_if #(
  parameter int DEPTH = 8
) ();
  localparam int CW = $clog2(DEPTH) + 1;

  logic [31:0]   PCResult_in;
  logic [31:0]   WriteData_in;
  logic          step;
  logic [6:0]    out7;
  logic [7:0]    en_out;
  logic [CW-1:0] count;
  logic          overflow;
  logic          dbg_state;
  logic          dbg_load;
  logic [31:0]   dbg_disp;

  modport master (
    output PCResult_in, WriteData_in, step,
    input  out7, en_out, count, overflow, dbg_state, dbg_load, dbg_disp
  );

  modport slave (
    input  PCResult_in, WriteData_in, step,
    output out7, en_out, count, overflow, dbg_state, dbg_load, dbg_disp
  );
endinterface

// File: rtl/wb_trace_buffer.sv
// Captures {PC, WriteData} whenever the fetch PC changes, queues the snapshots and
// replays them on an eight-digit multiplexed seven-segment display at human speed.
module wb_trace_buffer #(
  parameter int DEPTH = 8,
  parameter int DWELL = 100_000_000,
  parameter int SCAN  = 100_000
) (
  input  logic            Clk,
  input  logic            rst,
  wb_trace_buffer_if.slave bus
);
  localparam int AW  = $clog2(DEPTH);
  localparam int CW  = AW + 1;
  localparam int DWW = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam int SCW = (SCAN > 1) ? $clog2(SCAN) : 1;
  localparam logic [6:0] DASH = 7'b0111111;

  typedef enum logic {IDLE = 1'b0, SHOW = 1'b1} state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [31:0]     r_mem [DEPTH];
  logic [AW-1:0]   r_wr_ptr;
  logic [AW-1:0]   r_rd_ptr;
  logic [CW-1:0]   r_count;
  logic            r_overflow;
  logic            r_first;
  logic [31:0]     r_last_pc;
  logic            r_step_s;
  logic            r_step_q;
  logic [DWW-1:0]  r_dwell;
  logic [SCW-1:0]  r_scan;
  logic [2:0]      r_idx;
  logic [31:0]     r_disp;
  logic            r_disp_valid;
  logic            r_load;
  logic [6:0]      r_out7;
  logic [7:0]      r_en_out;

  logic            w_push_req;
  logic            w_push;
  logic            w_pop;
  logic            w_full;
  logic            w_empty;
  logic            w_step_edge;
  logic            w_dwell_end;
  logic [31:0]     w_entry;
  logic [3:0]      w_nibble;

  function automatic logic [6:0] hex7(input logic [3:0] n);
    case (n)
      4'h0: hex7 = 7'b1000000;
      4'h1: hex7 = 7'b1111001;
      4'h2: hex7 = 7'b0100100;
      4'h3: hex7 = 7'b0110000;
      4'h4: hex7 = 7'b0011001;
      4'h5: hex7 = 7'b0010010;
      4'h6: hex7 = 7'b0000010;
      4'h7: hex7 = 7'b1111000;
      4'h8: hex7 = 7'b0000000;
      4'h9: hex7 = 7'b0010000;
      4'hA: hex7 = 7'b0001000;
      4'hB: hex7 = 7'b0000011;
      4'hC: hex7 = 7'b1000110;
      4'hD: hex7 = 7'b0100001;
      4'hE: hex7 = 7'b0000110;
      default: hex7 = 7'b0001110;
    endcase
  endfunction

  assign w_push_req  = r_first || (bus.PCResult_in != r_last_pc);
  assign w_full      = (r_count == CW'(DEPTH));
  assign w_empty     = (r_count == '0);
  // A full FIFO still accepts a push when the same cycle pops; an empty one never pops.
  assign w_push      = w_push_req && (!w_full || w_pop);
  assign w_step_edge = r_step_s && !r_step_q;
  assign w_dwell_end = (r_dwell == DWW'(DWELL - 1));
  assign w_entry     = {bus.PCResult_in[15:0], bus.WriteData_in[15:0]};
  assign w_nibble    = r_disp[{r_idx, 2'b00} +: 4];

  always_comb begin
    w_state_nxt = r_state;
    w_pop       = 1'b0;
    case (r_state)
      IDLE: begin
        if (!w_empty) begin
          w_pop       = 1'b1;
          w_state_nxt = SHOW;
        end
      end
      SHOW: begin
        if (w_dwell_end || w_step_edge) begin
          if (!w_empty) w_pop = 1'b1;
          else          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (w_push) r_mem[r_wr_ptr] <= w_entry;
  end

  always_ff @(posedge Clk) begin
    if (!rst) begin
      r_state      <= IDLE;
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_count      <= '0;
      r_overflow   <= 1'b0;
      r_first      <= 1'b1;
      r_last_pc    <= '0;
      r_step_s     <= 1'b0;
      r_step_q     <= 1'b0;
      r_dwell      <= '0;
      r_scan       <= '0;
      r_idx        <= '0;
      r_disp       <= '0;
      r_disp_valid <= 1'b0;
      r_load       <= 1'b0;
      r_out7       <= DASH;
      r_en_out     <= 8'b1111_1110;
    end else begin
      r_state  <= w_state_nxt;
      r_step_s <= bus.step;
      r_step_q <= r_step_s;
      r_load   <= w_pop;

      if (w_push_req) begin
        r_last_pc <= bus.PCResult_in;
        r_first   <= 1'b0;
      end
      if (w_push_req && w_full && !w_pop) r_overflow <= 1'b1;

      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop) begin
        r_rd_ptr     <= r_rd_ptr + 1'b1;
        r_disp       <= r_mem[r_rd_ptr];
        r_disp_valid <= 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase

      // Every dwell end either pops or drops to IDLE, so the counter never runs past DWELL-1.
      if (w_pop || (w_state_nxt == IDLE)) r_dwell <= '0;
      else                                r_dwell <= r_dwell + 1'b1;

      if (r_scan == SCW'(SCAN - 1)) begin
        r_scan <= '0;
        r_idx  <= r_idx + 1'b1;
      end else begin
        r_scan <= r_scan + 1'b1;
      end

      r_en_out <= ~(8'd1 << r_idx);
      r_out7   <= r_disp_valid ? hex7(w_nibble) : DASH;
    end
  end

  assign bus.out7      = r_out7;
  assign bus.en_out    = r_en_out;
  assign bus.count     = r_count;
  assign bus.overflow  = r_overflow;
  assign bus.dbg_state = r_state;
  assign bus.dbg_load  = r_load;
  assign bus.dbg_disp  = r_disp;
endmodule

// File: tb/tb_wb_trace_buffer.sv
// Directed bench for wb_trace_buffer (DEPTH=4, DWELL=5, SCAN=2) with a load scoreboard.
module tb_wb_trace_buffer;
  logic Clk = 1'b0;
  logic rst = 1'b0;
  int   cyc = 0;
  int   base = 0;
  int   n_pass = 0;
  int   n_total = 0;

  logic [31:0] exp_q[$];
  int          exp_t_q[$];

  wb_trace_buffer_if #(.DEPTH(4)) bus ();

  wb_trace_buffer #(.DEPTH(4), .DWELL(5), .SCAN(2)) dut (
    .Clk(Clk),
    .rst(rst),
    .bus(bus.slave)
  );

  // clock / reset
  always #5 Clk = ~Clk;
  always @(posedge Clk) cyc <= cyc + 1;

  initial begin
    #100000;
    $display("FAIL watchdog: got time limit reached, required end of stimulus");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, required %h (cycle %0d)", name, act, exp, cyc);
  endtask

  // driver tasks
  task automatic wait_to(input int k);
    while (cyc < k) begin
      @(posedge Clk);
      #1;
    end
  endtask

  task automatic at_neg(input int k);
    wait_to(k);
    @(negedge Clk);
  endtask

  task automatic drive(input logic [31:0] pc, input logic [31:0] wd);
    bus.PCResult_in  = pc;
    bus.WriteData_in = wd;
  endtask

  task automatic push_exp(input logic [31:0] entry, input int t);
    exp_q.push_back(entry);
    exp_t_q.push_back(t);
  endtask

  task automatic do_reset(input logic [31:0] pc, input logic [31:0] wd);
    rst = 1'b0;
    bus.step = 1'b0;
    drive(pc, wd);
    exp_q.delete();
    exp_t_q.delete();
    repeat (2) @(posedge Clk);
    #1;
    rst  = 1'b1;
    base = cyc;
  endtask

  // scoreboard monitor: every display load must match the next queued entry and time
  always @(negedge Clk) begin
    if (bus.dbg_load === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_total++;
        $display("FAIL unexpected_load: got %h at cycle %0d, required no load", bus.dbg_disp, cyc);
      end else begin
        logic [31:0] e;
        int          t;
        e = exp_q.pop_front();
        t = exp_t_q.pop_front();
        check("load_value", bus.dbg_disp, e);
        check("load_cycle", 32'(cyc), 32'(t));
      end
    end
  end

  // hand-computed vectors
  int          t2_cnt [8]  = '{0, 1, 2, 3, 3, 4, 4, 4};
  logic        t2_ovf [8]  = '{0, 0, 0, 0, 0, 0, 1, 1};
  int          t2_load[5]  = '{7, 12, 17, 22, 27};
  logic [31:0] t2_ent [5]  = '{32'h0000_A000, 32'h0004_A004, 32'h0008_A008, 32'h000C_A00C, 32'h0010_A010};
  logic [31:0] t3_ent [5]  = '{32'h0210_3210, 32'h0220_3220, 32'h0230_3230, 32'h0240_3240, 32'h0250_3250};
  logic [7:0]  t5_en  [8]  = '{8'hFE, 8'hFD, 8'hFB, 8'hF7, 8'hEF, 8'hDF, 8'hBF, 8'h7F};
  logic [6:0]  t5_seg [8]  = '{7'h19, 7'h30, 7'h24, 7'h79, 7'h03, 7'h08, 7'h40, 7'h40};

  initial begin
    int t;
    bus.step = 1'b0;
    drive('0, '0);

    // 1: reset state, single capture of PC=0, dash until the first load reaches out7
    do_reset(32'h0000_0000, 32'h0000_1234);
    push_exp(32'h0000_1234, base + 2);
    at_neg(base);
    check("t1_rst_count", 32'(bus.count), 0);
    check("t1_rst_overflow", 32'(bus.overflow), 0);
    check("t1_rst_out7", 32'(bus.out7), 32'h3F);
    check("t1_rst_en_out", 32'(bus.en_out), 32'hFE);
    at_neg(base + 1);
    check("t1_count_one", 32'(bus.count), 1);
    check("t1_dash_pre", 32'(bus.out7), 32'h3F);
    at_neg(base + 2);
    check("t1_count_popped", 32'(bus.count), 0);
    check("t1_dash_load", 32'(bus.out7), 32'h3F);
    check("t1_state_show", 32'(bus.dbg_state), 1);
    at_neg(base + 3);
    check("t1_out7_digit1", 32'(bus.out7), 32'h30);
    check("t1_en_digit1", 32'(bus.en_out), 32'hFD);

    // 2: PC changes every cycle while showing; saturation, overflow, replay order
    do_reset(32'h0000_0100, 32'hFFFF_A100);
    push_exp(32'h0100_A100, base + 2);
    for (int i = 0; i < 8; i++) begin
      wait_to(base + 3 + i);
      drive(32'(4 * i), 32'hFFFF_A000 + 32'(4 * i));
      if (i < 5) push_exp(t2_ent[i], base + t2_load[i]);
      @(negedge Clk);
      check("t2_count", 32'(bus.count), 32'(t2_cnt[i]));
      check("t2_overflow", 32'(bus.overflow), 32'(t2_ovf[i]));
    end
    at_neg(base + 12);
    check("t2_count_after_pop", 32'(bus.count), 3);
    check("t2_overflow_sticky", 32'(bus.overflow), 1);
    at_neg(base + 33);
    check("t2_idle", 32'(bus.dbg_state), 0);

    // 6: reset mid-SHOW with three entries queued and overflow set
    t = base + 35;
    wait_to(t);
    drive(32'h0000_0600, 32'h0000_6666);
    push_exp(32'h0600_6666, t + 2);
    wait_to(t + 1);
    drive(32'h0000_0610, 32'h0000_6661);
    wait_to(t + 2);
    drive(32'h0000_0620, 32'h0000_6662);
    wait_to(t + 3);
    drive(32'h0000_0630, 32'h0000_6663);
    at_neg(t + 4);
    check("t6_count_pre", 32'(bus.count), 3);
    check("t6_overflow_pre", 32'(bus.overflow), 1);
    wait_to(t + 5);
    rst = 1'b0;
    exp_q.delete();
    exp_t_q.delete();
    @(negedge Clk);
    check("t6_count_before_edge", 32'(bus.count), 3);
    at_neg(t + 6);
    check("t6_count", 32'(bus.count), 0);
    check("t6_overflow", 32'(bus.overflow), 0);
    check("t6_out7", 32'(bus.out7), 32'h3F);
    check("t6_en_out", 32'(bus.en_out), 32'hFE);

    // 3: full FIFO, pop at dwell boundary with a simultaneous push
    do_reset(32'h1234_0200, 32'h0000_3200);
    push_exp(32'h0200_3200, base + 2);
    for (int i = 0; i < 5; i++) begin
      wait_to(base + 2 + i);
      drive(32'h1234_0210 + 32'(16 * i), 32'h0000_3210 + 32'(16 * i));
      push_exp(t3_ent[i], base + 7 + 5 * i);
      @(negedge Clk);
      check("t3_count", 32'(bus.count), 32'(i));
    end
    at_neg(base + 7);
    check("t3_count_full_kept", 32'(bus.count), 4);
    check("t3_no_overflow", 32'(bus.overflow), 0);
    wait_to(base + 35);

    // 4: step pulse cuts the dwell short; step in IDLE is ignored
    do_reset(32'h0000_0300, 32'h0000_4300);
    push_exp(32'h0300_4300, base + 2);
    wait_to(base + 1);
    drive(32'h0000_0310, 32'h0000_4310);
    push_exp(32'h0310_4310, base + 5);
    wait_to(base + 2);
    drive(32'h0000_0320, 32'h0000_4320);
    push_exp(32'h0320_4320, base + 10);
    wait_to(base + 3);
    bus.step = 1'b1;
    @(negedge Clk);
    check("t4_count_at_step", 32'(bus.count), 2);
    wait_to(base + 4);
    bus.step = 1'b0;
    @(negedge Clk);
    check("t4_count_no_pop_yet", 32'(bus.count), 2);
    at_neg(base + 5);
    check("t4_count_after_step", 32'(bus.count), 1);
    at_neg(base + 10);
    check("t4_count_dwell_end", 32'(bus.count), 0);
    wait_to(base + 17);
    bus.step = 1'b1;
    wait_to(base + 18);
    bus.step = 1'b0;
    at_neg(base + 24);
    check("t4_idle_after_step", 32'(bus.dbg_state), 0);

    // 5: digit scan of 0x00AB / 0x1234 over 16 cycles
    do_reset(32'h0000_00AB, 32'h0000_1234);
    push_exp(32'h00AB_1234, base + 2);
    for (int k = 20; k < 36; k++) begin
      int d;
      at_neg(base + k);
      d = ((k - 1) / 2) % 8;
      check("t5_en_out", 32'(bus.en_out), 32'(t5_en[d]));
      check("t5_out7", 32'(bus.out7), 32'(t5_seg[d]));
    end

    wait_to(base + 40);
    check("scoreboard_drained", 32'(exp_q.size()), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
